decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
//  Instruction-decode stage directly downstream of fetch. Consumes fetch's pc_n/instr_raw
//  under the same enabled/completed handshake. Registers a fully decoded RV32I view
//  (register indices, sign-extended immediate, ALU op, control flags) for execute.
//  Flags unknown opcodes as illegal.
// PARAMETERS
//  XLEN       32  datapath/immediate width; only 32 is supported
//  HOLD_LAST  1   1: outputs hold the last decode until the next enabled; 0: outputs zero on enabled
// PORTS
//  clk        in   1     single clock, rising edge
//  rstn       in   1     reset, asynchronous, active-low
//  enabled    in   1     controller request; sample pc/instr_raw every cycle it is high
//  pc         in   32    instruction index from fetch (fetch pc_n)
//  instr_raw  in   32    raw instruction word from fetch
//  completed  out  1     decode result valid; = done_r & ~enabled
//  pc_n       out  32    pc of the decoded instruction, passed through
//  rd,rs1,rs2 out  5     register indices (0 when field unused by format)
//  imm        out  32    sign-extended immediate per format (0 for R-type)
//  funct3     out  3     instr_raw[14:12]
//  alu_op     out  4     alu_op_t (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND)
//  ctrl       out  10    {is_lui,is_auipc,is_jal,is_jalr,is_branch,is_load,is_store,uses_imm,writes_rd,illegal}
// BEHAVIOUR
//  - Reset (rstn=0, async): done_r=0, pc_n=0, rd/rs1/rs2=0, imm=0, funct3=0, alu_op=ADD, ctrl=0.
//    Reset asserted mid-operation discards the in-flight decode immediately. Reset wins over enabled.
//  - FSM states: IDLE (after reset) -> LATCH (enabled=1: sample and decode; done_r<=1)
//    -> DONE (enabled=0, completed=1). DONE -> LATCH on the next enabled.
//  - completed rises the first cycle enabled is low after a latch; it is masked while enabled=1.
//  - Latency: outputs are valid the cycle after the last enabled cycle.
//    A multi-cycle enabled re-latches every cycle; the last sample wins.
//  - Decode is combinational from instr_raw and registered once; there is no other state.
//  - Immediates: I = sext(ir[31:20]); S = sext({ir[31:25],ir[11:7]});
//    B = sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}); U = {ir[31:12],12'b0};
//    J = sext({ir[31],ir[19:12],ir[20],ir[30:21],1'b0}).
//  - alu_op: OP/OP-IMM use funct3, with funct7[5] selecting SUB/SRA. For OP-IMM, bit30 applies to SRAI only.
//    LOAD/STORE/JAL/JALR/LUI/AUIPC use ADD. BRANCH uses SUB for BEQ/BNE and SLT/SLTU for the signed/unsigned compares.
//  - writes_rd = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP and OP-IMM; it is forced to 0 when rd==0.
//  - Illegal opcode: illegal=1, all other ctrl bits 0, alu_op=ADD, imm=0.
//    completed still asserts; the illegal flag does not block the handshake.
//  - HOLD_LAST=0: on enabled, outputs other than pc_n clear to their reset values before the new decode registers.
// STRUCTURE
//  - In the def.sv package: the opcode constants (LUI..OP), alu_op_t enum, ctrl bit-index
//    localparams, and the imm_fmt_t enum (R, I, S, B, U, J).
//  - Sub-module decode_imm (combinational; instr_raw, imm_fmt_t -> imm[31:0]).
//    Everything else, including the FSM and output registers, lives in decode.
// TESTING
//  - Reset: assert rstn=0 mid-LATCH -> all outputs 0 the same cycle; completed=0 until the next enabled pulse.
//  - 0x074000EF (jal ra,0x74), pc=0, 1-cycle enabled -> next cycle completed=1, rd=1, imm=0x74,
//    is_jal=1, writes_rd=1, pc_n=0.
//  - 0xFE010113 (addi sp,sp,-32) -> rd=2, rs1=2, imm=0xFFFFFFE0, alu_op=ADD, uses_imm=1.
//  - 0x00112E23 (sw ra,28(sp)) -> rs1=2, rs2=1, imm=28, is_store=1, writes_rd=0.
//    0x00E7C663 (blt a5,a4,+12) -> rs1=15, rs2=14, imm=12, is_branch=1, alu_op=SLT.
//  - 0x00008067 (ret) -> is_jalr=1, rs1=1, rd=0, writes_rd=0. 0xFFFFFFFF -> illegal=1, ctrl otherwise 0, completed=1.
//  - Back-to-back: enabled high 3 cycles (words A, B, C) -> completed stays 0 throughout; outputs decode C after enabled falls.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, control-vector bit
// positions, immediate formats and the decode FSM states.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // ctrl = {is_lui,is_auipc,is_jal,is_jalr,is_branch,is_load,is_store,uses_imm,writes_rd,illegal}
  localparam int CTRL_ILLEGAL   = 0;
  localparam int CTRL_WRITES_RD = 1;
  localparam int CTRL_USES_IMM  = 2;
  localparam int CTRL_IS_STORE  = 3;
  localparam int CTRL_IS_LOAD   = 4;
  localparam int CTRL_IS_BRANCH = 5;
  localparam int CTRL_IS_JALR   = 6;
  localparam int CTRL_IS_JAL    = 7;
  localparam int CTRL_IS_AUIPC  = 8;
  localparam int CTRL_IS_LUI    = 9;
  localparam int CTRL_W         = 10;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // OP / OP-IMM share the funct3 map; alt selects SUB or SRA where it applies.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_imm.sv
// Combinational immediate generator: extracts and sign-extends the immediate
// for the given RV32I instruction format; R-type yields zero.
module decode_imm
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I instruction-decode stage: decodes fetch's instr_raw combinationally and
// registers the decoded view on every enabled cycle; completed follows the handshake.
module decode
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enabled,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr_raw,
  output logic            completed,
  output logic [XLEN-1:0] pc_n,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     imm,
  output logic [2:0]      funct3,
  output logic [3:0]      alu_op,
  output logic [9:0]      ctrl
);

  state_t state_reg, state_next;
  logic   done_reg, done_next;

  logic [XLEN-1:0]   pc_reg;
  logic [4:0]        rd_reg, rs1_reg, rs2_reg;
  logic [31:0]       imm_reg;
  logic [2:0]        funct3_reg;
  alu_op_t           alu_op_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  imm_fmt_t          fmt_next;
  alu_op_t           alu_op_next;
  logic [CTRL_W-1:0] ctrl_next;
  logic              use_rd, use_rs1, use_rs2;
  logic [31:0]       imm_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = done_reg;
    if (enabled) begin
      state_next = ST_LATCH;
      done_next  = 1'b1;
    end else if (state_reg == ST_LATCH) begin
      state_next = ST_DONE;
    end
  end

  assign completed = done_reg & ~enabled;

  always_comb begin
    fmt_next    = FMT_R;
    alu_op_next = ALU_ADD;
    ctrl_next   = '0;
    use_rd      = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (instr_raw[6:0])
      OPC_LUI: begin
        fmt_next = FMT_U;
        use_rd   = 1'b1;
        ctrl_next[CTRL_IS_LUI]    = 1'b1;
        ctrl_next[CTRL_USES_IMM]  = 1'b1;
        ctrl_next[CTRL_WRITES_RD] = 1'b1;
      end
      OPC_AUIPC: begin
        fmt_next = FMT_U;
        use_rd   = 1'b1;
        ctrl_next[CTRL_IS_AUIPC]  = 1'b1;
        ctrl_next[CTRL_USES_IMM]  = 1'b1;
        ctrl_next[CTRL_WRITES_RD] = 1'b1;
      end
      OPC_JAL: begin
        fmt_next = FMT_J;
        use_rd   = 1'b1;
        ctrl_next[CTRL_IS_JAL]    = 1'b1;
        ctrl_next[CTRL_USES_IMM]  = 1'b1;
        ctrl_next[CTRL_WRITES_RD] = 1'b1;
      end
      OPC_JALR: begin
        fmt_next = FMT_I;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        ctrl_next[CTRL_IS_JALR]   = 1'b1;
        ctrl_next[CTRL_USES_IMM]  = 1'b1;
        ctrl_next[CTRL_WRITES_RD] = 1'b1;
      end
      OPC_BRANCH: begin
        fmt_next = FMT_B;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        ctrl_next[CTRL_IS_BRANCH] = 1'b1;
        case (instr_raw[14:13])
          2'b10:   alu_op_next = ALU_SLT;
          2'b11:   alu_op_next = ALU_SLTU;
          default: alu_op_next = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        fmt_next = FMT_I;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        ctrl_next[CTRL_IS_LOAD]   = 1'b1;
        ctrl_next[CTRL_USES_IMM]  = 1'b1;
        ctrl_next[CTRL_WRITES_RD] = 1'b1;
      end
      OPC_STORE: begin
        fmt_next = FMT_S;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        ctrl_next[CTRL_IS_STORE]  = 1'b1;
        ctrl_next[CTRL_USES_IMM]  = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt_next = FMT_I;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        // bit30 is an immediate bit except for the shift-right encoding
        alu_op_next = alu_from_funct3(instr_raw[14:12],
                                      instr_raw[30] & (instr_raw[14:12] == 3'b101));
        ctrl_next[CTRL_USES_IMM]  = 1'b1;
        ctrl_next[CTRL_WRITES_RD] = 1'b1;
      end
      OPC_OP: begin
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        alu_op_next = alu_from_funct3(instr_raw[14:12], instr_raw[30]);
        ctrl_next[CTRL_WRITES_RD] = 1'b1;
      end
      default: ctrl_next[CTRL_ILLEGAL] = 1'b1;
    endcase
    if (instr_raw[11:7] == 5'd0) ctrl_next[CTRL_WRITES_RD] = 1'b0;
  end

  decode_imm u_imm (
    .instr (instr_raw),
    .fmt   (fmt_next),
    .imm   (imm_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_reg     <= '0;
      rd_reg     <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      imm_reg    <= '0;
      funct3_reg <= '0;
      alu_op_reg <= ALU_ADD;
      ctrl_reg   <= '0;
    end else if (enabled) begin
      pc_reg     <= pc;
      rd_reg     <= use_rd  ? instr_raw[11:7]  : 5'd0;
      rs1_reg    <= use_rs1 ? instr_raw[19:15] : 5'd0;
      rs2_reg    <= use_rs2 ? instr_raw[24:20] : 5'd0;
      imm_reg    <= imm_next;
      funct3_reg <= instr_raw[14:12];
      alu_op_reg <= alu_op_next;
      ctrl_reg   <= ctrl_next;
    end
  end

  assign pc_n = pc_reg;

  // Without HOLD_LAST the decoded view reads as reset values while a new request is open.
  if (HOLD_LAST) begin : g_hold
    assign rd     = rd_reg;
    assign rs1    = rs1_reg;
    assign rs2    = rs2_reg;
    assign imm    = imm_reg;
    assign funct3 = funct3_reg;
    assign alu_op = alu_op_reg;
    assign ctrl   = ctrl_reg;
  end else begin : g_clear
    assign rd     = enabled ? 5'd0    : rd_reg;
    assign rs1    = enabled ? 5'd0    : rs1_reg;
    assign rs2    = enabled ? 5'd0    : rs2_reg;
    assign imm    = enabled ? 32'd0   : imm_reg;
    assign funct3 = enabled ? 3'd0    : funct3_reg;
    assign alu_op = enabled ? ALU_ADD : alu_op_reg;
    assign ctrl   = enabled ? 10'd0   : ctrl_reg;
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: expected decodes are queued when an
// instruction is sent and compared when completed is observed.
module tb_decode;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        enabled = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr_raw = '0;
  logic        completed;
  logic [31:0] pc_n;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic [9:0]  ctrl;

  always #5 clk = ~clk;

  decode #(.XLEN(32), .HOLD_LAST(1'b1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enabled   (enabled),
    .pc        (pc),
    .instr_raw (instr_raw),
    .completed (completed),
    .pc_n      (pc_n),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .funct3    (funct3),
    .alu_op    (alu_op),
    .ctrl      (ctrl)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [9:0]  ctrl;
    logic [9:0]  cmask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  localparam logic [9:0] ALL     = 10'h3FF;
  localparam logic [9:0] NO_UIMM = 10'h3FB;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [4:0] e_rd, input logic [4:0] e_rs1,
                      input logic [4:0] e_rs2, input logic [31:0] e_imm, input logic [2:0] e_f3,
                      input logic [3:0] e_alu, input logic [9:0] e_ctrl, input logic [9:0] e_mask);
    exp_t e;
    e.pc = p; e.rd = e_rd; e.rs1 = e_rs1; e.rs2 = e_rs2; e.imm = e_imm;
    e.f3 = e_f3; e.alu = e_alu; e.ctrl = e_ctrl; e.cmask = e_mask;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] p);
    @(negedge clk);
    enabled   = 1'b1;
    instr_raw = w;
    pc        = p;
  endtask

  // Drop enabled, wait (bounded) for completed, then compare against the queue head.
  task automatic release_and_check(input string tag);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    enabled = 1'b0;
    #1;
    while (completed !== 1'b1 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, ".completed"}, {31'd0, completed}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".pc_n"},   pc_n,            e.pc);
      check({tag, ".rd"},     {27'd0, rd},     {27'd0, e.rd});
      check({tag, ".rs1"},    {27'd0, rs1},    {27'd0, e.rs1});
      check({tag, ".rs2"},    {27'd0, rs2},    {27'd0, e.rs2});
      check({tag, ".imm"},    imm,             e.imm);
      check({tag, ".funct3"}, {29'd0, funct3}, {29'd0, e.f3});
      check({tag, ".alu_op"}, {28'd0, alu_op}, {28'd0, e.alu});
      check({tag, ".ctrl"},   {22'd0, ctrl & e.cmask}, {22'd0, e.ctrl & e.cmask});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".completed"}, {31'd0, completed}, 32'd0);
    check({tag, ".pc_n"},   pc_n,            32'd0);
    check({tag, ".regs"},   {17'd0, rd, rs1, rs2}, 32'd0);
    check({tag, ".imm"},    imm,             32'd0);
    check({tag, ".funct3"}, {29'd0, funct3}, 32'd0);
    check({tag, ".alu_op"}, {28'd0, alu_op}, {28'd0, ALU_ADD});
    check({tag, ".ctrl"},   {22'd0, ctrl},   32'd0);
  endtask

  initial begin
    // power-on reset
    #1 rstn = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1 check("post_reset_idle", {31'd0, completed}, 32'd0);

    send(32'h074000EF, 32'd0);
    push(32'd0, 5'd1, 5'd0, 5'd0, 32'h74, 3'd0, ALU_ADD, 10'h082, NO_UIMM);
    release_and_check("jal");

    // result holds while enabled stays low
    @(negedge clk);
    #1 check("jal_hold.completed", {31'd0, completed}, 32'd1);
    check("jal_hold.imm", imm, 32'h74);

    send(32'hFE010113, 32'd1);
    #1 check("addi_masked.completed", {31'd0, completed}, 32'd0);
    push(32'd1, 5'd2, 5'd2, 5'd0, 32'hFFFFFFE0, 3'd0, ALU_ADD, 10'h006, ALL);
    release_and_check("addi");

    send(32'h00112E23, 32'd2);
    push(32'd2, 5'd0, 5'd2, 5'd1, 32'd28, 3'd2, ALU_ADD, 10'h00C, ALL);
    release_and_check("sw");

    send(32'h00E7C663, 32'd3);
    push(32'd3, 5'd0, 5'd15, 5'd14, 32'd12, 3'd4, ALU_SLT, 10'h020, ALL);
    release_and_check("blt");

    send(32'h00008067, 32'd4);
    push(32'd4, 5'd0, 5'd1, 5'd0, 32'd0, 3'd0, ALU_ADD, 10'h040, NO_UIMM);
    release_and_check("ret");

    send(32'hFFFFFFFF, 32'd5);
    push(32'd5, 5'd0, 5'd0, 5'd0, 32'd0, 3'd7, ALU_ADD, 10'h001, ALL);
    release_and_check("illegal");

    send(32'h40B50533, 32'd6);
    push(32'd6, 5'd10, 5'd10, 5'd11, 32'd0, 3'd0, ALU_SUB, 10'h002, ALL);
    release_and_check("sub");

    send(32'h40355513, 32'd7);
    push(32'd7, 5'd10, 5'd10, 5'd0, 32'h403, 3'd5, ALU_SRA, 10'h006, ALL);
    release_and_check("srai");

    send(32'h12345537, 32'd8);
    push(32'd8, 5'd10, 5'd0, 5'd0, 32'h12345000, 3'd5, ALU_ADD, 10'h206, NO_UIMM);
    release_and_check("lui");

    // back-to-back: three enabled cycles, last sample wins
    send(32'hFE010113, 32'd20);
    #1 check("b2b_a.completed", {31'd0, completed}, 32'd0);
    send(32'h00112E23, 32'd21);
    #1 check("b2b_b.completed", {31'd0, completed}, 32'd0);
    send(32'h00E7C663, 32'd22);
    #1 check("b2b_c.completed", {31'd0, completed}, 32'd0);
    push(32'd22, 5'd0, 5'd15, 5'd14, 32'd12, 3'd4, ALU_SLT, 10'h020, ALL);
    release_and_check("b2b");

    // reset asserted mid-LATCH discards the decode immediately
    send(32'hFE010113, 32'h40);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    enabled = 1'b0;
    rstn    = 1'b1;
    @(negedge clk);
    #1 check("mid_reset_idle1", {31'd0, completed}, 32'd0);
    @(negedge clk);
    #1 check("mid_reset_idle2", {31'd0, completed}, 32'd0);

    send(32'h074000EF, 32'h44);
    push(32'h44, 5'd1, 5'd0, 5'd0, 32'h74, 3'd0, ALU_ADD, 10'h082, NO_UIMM);
    release_and_check("jal_after_reset");

    check("queue_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
